// File: rtl/ppu_vram_port.sv
// CPU-side VRAM access port: PPUCTRL increment, PPUADDR double-write latch, PPUDATA read/write path.
// Optional feature macro PPU_VRAM_INC32_EN: when defined, ctrl[2] selects a +32 address increment.
module ppu_vram_port #(
    parameter int VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_sel,
    input  logic               cpu_r_nw,
    input  logic [1:0]         cpu_reg,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    output logic               busy,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_wr,
    output logic [7:0]         vram_din,
    input  logic [7:0]         vram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RA   = 2'd2,
        ST_RC   = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_ADDR   = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VRAM_AW-1:0] r_v;
    logic [5:0]         r_t_hi;
    logic               r_w;
    logic [7:0]         r_ctrl;
    logic [7:0]         r_rbuf;
    logic [7:0]         r_cpu_dout;
    logic [7:0]         r_wdata;

    logic               w_accept;
    logic               w_ctrl_wr;
    logic               w_ctrl_rd;
    logic               w_status_rd;
    logic               w_addr_wr;
    logic               w_addr_rd;
    logic               w_data_wr;
    logic               w_data_rd;
    logic               w_step;
    logic [VRAM_AW-1:0] w_inc;
    logic [VRAM_AW-1:0] w_v_load;

    // Strobes arriving while a VRAM sequence runs are dropped here, before any decode.
    assign w_accept    = cpu_sel && (r_state == ST_IDLE);
    assign w_ctrl_wr   = w_accept && (cpu_reg == REG_CTRL)   && !cpu_r_nw;
    assign w_ctrl_rd   = w_accept && (cpu_reg == REG_CTRL)   &&  cpu_r_nw;
    assign w_status_rd = w_accept && (cpu_reg == REG_STATUS) &&  cpu_r_nw;
    assign w_addr_wr   = w_accept && (cpu_reg == REG_ADDR)   && !cpu_r_nw;
    assign w_addr_rd   = w_accept && (cpu_reg == REG_ADDR)   &&  cpu_r_nw;
    assign w_data_wr   = w_accept && (cpu_reg == REG_DATA)   && !cpu_r_nw;
    assign w_data_rd   = w_accept && (cpu_reg == REG_DATA)   &&  cpu_r_nw;

    assign w_step   = (r_state == ST_WR) || (r_state == ST_RC);
    assign w_v_load = VRAM_AW'({r_t_hi, cpu_din});

`ifdef PPU_VRAM_INC32_EN
    assign w_inc = r_ctrl[2] ? VRAM_AW'(7'd32) : VRAM_AW'(1'b1);
`else
    assign w_inc = VRAM_AW'(1'b1);
`endif

    assign cpu_dout  = r_cpu_dout;
    assign busy      = (r_state != ST_IDLE);
    assign vram_addr = r_v;
    assign vram_wr   = (r_state == ST_WR);
    assign vram_din  = r_wdata;

    // Sequence state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode for the DATA access sequences.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_data_wr) begin
                    w_state_nxt = ST_WR;
                end else if (w_data_rd) begin
                    w_state_nxt = ST_RA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR:   w_state_nxt = ST_IDLE;
            ST_RA:   w_state_nxt = ST_RC;
            ST_RC:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Current VRAM address: post-access increment or second ADDR write load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (w_step) begin
            r_v <= r_v + w_inc;
        end else if (w_addr_wr && r_w) begin
            r_v <= w_v_load;
        end
    end

    // ADDR high-byte latch and the shared write toggle (cleared by a STATUS read).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t_hi <= 6'd0;
            r_w    <= 1'b0;
        end else if (w_status_rd) begin
            r_w <= 1'b0;
        end else if (w_addr_wr) begin
            if (!r_w) begin
                r_t_hi <= cpu_din[5:0];
            end
            r_w <= ~r_w;
        end
    end

    // PPUCTRL register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= 8'h00;
        end else if (w_ctrl_wr) begin
            r_ctrl <= cpu_din;
        end
    end

    // CPU read data; holds until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_dout <= 8'h00;
        end else if (w_ctrl_rd) begin
            r_cpu_dout <= r_ctrl;
        end else if (w_status_rd || w_addr_rd) begin
            r_cpu_dout <= 8'h00;
        end else if (w_data_rd) begin
            r_cpu_dout <= r_rbuf;
        end
    end

    // One-deep read buffer, filled one cycle after the address is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbuf <= 8'h00;
        end else if (r_state == ST_RC) begin
            r_rbuf <= vram_dout;
        end
    end

    // Write data captured at the DATA write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdata <= 8'h00;
        end else if (w_data_wr) begin
            r_wdata <= cpu_din;
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: vector table plus hand sequences, write pulses checked by a scoreboard.
module tb_ppu_vram_port;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_ADDR   = 2'd2;
    localparam logic [1:0] R_DATA   = 2'd3;

`ifdef PPU_VRAM_INC32_EN
    localparam logic [13:0] A_WRAP    = 14'h0010;
    localparam logic [13:0] A_WRAP_RD = 14'h0030;
    localparam logic [13:0] V_RST     = 14'h2420;
`else
    localparam logic [13:0] A_WRAP    = 14'h3FF1;
    localparam logic [13:0] A_WRAP_RD = 14'h3FF2;
    localparam logic [13:0] V_RST     = 14'h2401;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_sel;
    logic        cpu_r_nw;
    logic [1:0]  cpu_reg;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;

    logic [7:0]  mem [0:16383];

    typedef struct {
        logic [1:0]  r;
        logic        rnw;
        logic [7:0]  din;
        logic [7:0]  dout;
        logic [13:0] addr;
    } vec_t;

    typedef struct {
        logic [13:0] a;
        logic [7:0]  d;
    } wr_t;

    localparam int NV = 31;
    vec_t        vecs [NV];
    wr_t         wr_q [$];
    logic [7:0]  rd_q [$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [13:0] cur_v;

    ppu_vram_port #(.VRAM_AW(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_sel   (cpu_sel),
        .cpu_r_nw  (cpu_r_nw),
        .cpu_reg   (cpu_reg),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .busy      (busy),
        .vram_addr (vram_addr),
        .vram_wr   (vram_wr),
        .vram_din  (vram_din),
        .vram_dout (vram_dout)
    );

    always #10 clk = ~clk;

    // Memory controller model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        vram_dout <= mem[vram_addr];
        if (vram_wr) mem[vram_addr] <= vram_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && vram_wr) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL extra_wr: got pulse addr %0h data %0h expected no pulse", vram_addr, vram_din);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(vram_addr), 32'(e.a));
                check("wr_data", 32'(vram_din), 32'(e.d));
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++;
            n_err++;
            $display("FAIL busy_timeout: got busy=1 after 20 cycles expected 0");
        end
    endtask

    task automatic access(input logic [1:0] r, input logic rnw, input logic [7:0] d,
                          input logic [7:0] exp_dout, input logic [13:0] v_now);
        logic [7:0] e;
        wait_idle();
        if (!rnw && r == R_DATA) wr_q.push_back('{a: v_now, d: d});
        if (rnw) rd_q.push_back(exp_dout);
        @(negedge clk);
        cpu_sel = 1'b1; cpu_r_nw = rnw; cpu_reg = r; cpu_din = d;
        @(negedge clk);
        cpu_sel = 1'b0;
        if (rnw) begin
            e = rd_q.pop_front();
            check("cpu_dout", 32'(cpu_dout), 32'(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_dout"},  32'(cpu_dout),  32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_vram_addr"}, 32'(vram_addr), 32'h0);
        check({tag, "_vram_wr"},   32'(vram_wr),   32'h0);
        check({tag, "_vram_din"},  32'(vram_din),  32'h0);
    endtask

    initial begin
        vecs[0]  = '{R_CTRL,   1'b1, 8'h00, 8'h00, 14'h0000};
        vecs[1]  = '{R_ADDR,   1'b0, 8'h21, 8'h00, 14'h0000};
        vecs[2]  = '{R_ADDR,   1'b0, 8'h08, 8'h00, 14'h2108};
        vecs[3]  = '{R_DATA,   1'b0, 8'h5A, 8'h00, 14'h2109};
        vecs[4]  = '{R_DATA,   1'b0, 8'h77, 8'h00, 14'h210A};
        vecs[5]  = '{R_ADDR,   1'b0, 8'h24, 8'h00, 14'h210A};
        vecs[6]  = '{R_ADDR,   1'b0, 8'h00, 8'h00, 14'h2400};
        vecs[7]  = '{R_DATA,   1'b1, 8'h00, 8'h00, 14'h2401};
        vecs[8]  = '{R_DATA,   1'b1, 8'h00, 8'hAA, 14'h2402};
        vecs[9]  = '{R_DATA,   1'b1, 8'h00, 8'hBB, 14'h2403};
        vecs[10] = '{R_ADDR,   1'b0, 8'h3F, 8'h00, 14'h2403};
        vecs[11] = '{R_STATUS, 1'b1, 8'h00, 8'h00, 14'h2403};
        vecs[12] = '{R_ADDR,   1'b0, 8'h20, 8'h00, 14'h2403};
        vecs[13] = '{R_ADDR,   1'b0, 8'h00, 8'h00, 14'h2000};
        vecs[14] = '{R_ADDR,   1'b1, 8'h00, 8'h00, 14'h2000};
        vecs[15] = '{R_STATUS, 1'b0, 8'h55, 8'h00, 14'h2000};
        vecs[16] = '{R_CTRL,   1'b0, 8'h04, 8'h00, 14'h2000};
        vecs[17] = '{R_CTRL,   1'b1, 8'h00, 8'h04, 14'h2000};
        vecs[18] = '{R_ADDR,   1'b0, 8'h3F, 8'h00, 14'h2000};
        vecs[19] = '{R_ADDR,   1'b0, 8'hF0, 8'h00, 14'h3FF0};
        vecs[20] = '{R_DATA,   1'b0, 8'h11, 8'h00, A_WRAP};
        vecs[21] = '{R_DATA,   1'b1, 8'h00, 8'hCC, A_WRAP_RD};
        vecs[22] = '{R_CTRL,   1'b0, 8'h00, 8'h00, A_WRAP_RD};
        vecs[23] = '{R_ADDR,   1'b0, 8'hFF, 8'h00, A_WRAP_RD};
        vecs[24] = '{R_ADDR,   1'b0, 8'hFF, 8'h00, 14'h3FFF};
        vecs[25] = '{R_DATA,   1'b0, 8'h22, 8'h00, 14'h0000};
        vecs[26] = '{R_ADDR,   1'b0, 8'h21, 8'h00, 14'h0000};
        vecs[27] = '{R_ADDR,   1'b0, 8'h08, 8'h00, 14'h2108};
        vecs[28] = '{R_DATA,   1'b1, 8'h00, 8'h00, 14'h2109};
        vecs[29] = '{R_DATA,   1'b1, 8'h00, 8'h5A, 14'h210A};
        vecs[30] = '{R_DATA,   1'b1, 8'h00, 8'h77, 14'h210B};

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h2400] = 8'hAA;
        mem[14'h2401] = 8'hBB;
        mem[14'h2402] = 8'hCC;

        rst = 1'b1; cpu_sel = 1'b0; cpu_r_nw = 1'b0; cpu_reg = 2'd0; cpu_din = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");

        cur_v = 14'h0000;
        for (int i = 0; i < NV; i++) begin
            access(vecs[i].r, vecs[i].rnw, vecs[i].din, vecs[i].dout, cur_v);
            wait_idle();
            check($sformatf("vec%0d_addr", i), 32'(vram_addr), 32'(vecs[i].addr));
            cur_v = vecs[i].addr;
        end

        // DATA write strobe held into the busy cycle: only one pulse, one increment.
        access(R_ADDR, 1'b0, 8'h30, 8'h00, 14'h0);
        access(R_ADDR, 1'b0, 8'h00, 8'h00, 14'h0);
        wait_idle();
        check("drop_base", 32'(vram_addr), 32'h3000);
        @(negedge clk);
        wr_q.push_back('{a: 14'h3000, d: 8'h44});
        cpu_sel = 1'b1; cpu_r_nw = 1'b0; cpu_reg = R_DATA; cpu_din = 8'h44;
        @(negedge clk);
        check("drop_busy_n1", 32'(busy), 32'h1);
        check("drop_wr_n1", 32'(vram_wr), 32'h1);
        cpu_din = 8'h99;
        @(negedge clk);
        cpu_sel = 1'b0;
        check("drop_busy_n2", 32'(busy), 32'h0);
        check("drop_addr_n2", 32'(vram_addr), 32'h3001);
        repeat (3) @(negedge clk);
        check("drop_addr_late", 32'(vram_addr), 32'h3001);

        // ADDR write dropped during busy must not disturb the toggle.
        access(R_ADDR, 1'b0, 8'h12, 8'h00, 14'h0);
        wait_idle();
        @(negedge clk);
        wr_q.push_back('{a: 14'h3001, d: 8'h66});
        cpu_sel = 1'b1; cpu_r_nw = 1'b0; cpu_reg = R_DATA; cpu_din = 8'h66;
        @(negedge clk);
        cpu_reg = R_ADDR; cpu_din = 8'h34;
        @(negedge clk);
        cpu_sel = 1'b0;
        access(R_ADDR, 1'b0, 8'h56, 8'h00, 14'h0);
        wait_idle();
        check("drop_toggle_addr", 32'(vram_addr), 32'h1256);

        // Reset in the middle of a write sequence.
        access(R_CTRL, 1'b0, 8'h84, 8'h00, 14'h0);
        access(R_ADDR, 1'b0, 8'h24, 8'h00, 14'h0);
        access(R_ADDR, 1'b0, 8'h00, 8'h00, 14'h0);
        access(R_DATA, 1'b1, 8'h00, 8'h00, 14'h0);
        access(R_ADDR, 1'b0, 8'h3F, 8'h00, 14'h0);
        access(R_CTRL, 1'b1, 8'h00, 8'h84, 14'h0);
        wait_idle();
        @(negedge clk);
        wr_q.push_back('{a: V_RST, d: 8'hE5});
        cpu_sel = 1'b1; cpu_r_nw = 1'b0; cpu_reg = R_DATA; cpu_din = 8'hE5;
        @(negedge clk);
        cpu_sel = 1'b0;
        check("rst_pre_wr", 32'(vram_wr), 32'h1);
        check("rst_pre_din", 32'(vram_din), 32'hE5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_wr", 32'(vram_wr), 32'h0);
        check("rst_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid");
        access(R_CTRL, 1'b1, 8'h00, 8'h00, 14'h0);
        access(R_DATA, 1'b1, 8'h00, 8'h00, 14'h0);
        access(R_ADDR, 1'b0, 8'h12, 8'h00, 14'h0);
        access(R_ADDR, 1'b0, 8'h34, 8'h00, 14'h0);
        wait_idle();
        check("rst_toggle_addr", 32'(vram_addr), 32'h1234);

        repeat (2) @(negedge clk);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
